// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: CPU/VPU requester and memory data-port signals shared through the arbiter
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              v_req;
  logic              v_lock;
  logic              v_we;
  logic [ADDR_W-1:0] v_addr;
  logic [DATA_W-1:0] v_wdata;
  logic              v_gnt;
  logic              v_rvalid;
  logic [DATA_W-1:0] v_rdata;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  v_req, v_lock, v_we, v_addr, v_wdata,
    output v_gnt, v_rvalid, v_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output v_req, v_lock, v_we, v_addr, v_wdata,
    input  v_gnt, v_rvalid, v_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin CPU/VPU arbiter for the memory data port with locked VPU bursts; CPU_MEM_ARB_PERF_EN adds wait counters
module cpu_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input logic clk,
  input logic rst,
  cpu_mem_arbiter_if.slave bus
`ifdef CPU_MEM_ARB_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [15:0] c_wait_cnt,
  output logic [15:0] v_wait_cnt
`endif
);
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [7:0] MAX = 8'(MAX_BURST);
  state_t            state;
  logic              rr_last;
  logic [7:0]        burst_cnt;
  logic [7:0]        cnt_nxt;
  logic [1:0]        rd_owner;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] v_rdata_q;
  logic              c_gnt;
  logic              v_gnt;
  logic              leave_burst;
  // Grant decision: round-robin tie-break in IDLE, V exclusive in BURST unless a forced release is due
  always_comb begin
    c_gnt = ~rst & (state == IDLE) & bus.c_req & (~bus.v_req | rr_last);
    v_gnt = ~rst & bus.v_req & ((state == IDLE) ? (~bus.c_req | ~rr_last) : ~(bus.c_req & (burst_cnt >= MAX)));
    cnt_nxt = (burst_cnt >= MAX) ? burst_cnt : burst_cnt + 8'd1;
    leave_burst = ~bus.v_req | (v_gnt & ~bus.v_lock) | (bus.c_req & ((v_gnt ? cnt_nxt : burst_cnt) >= MAX));
  end
  assign bus.c_gnt     = c_gnt;
  assign bus.v_gnt     = v_gnt;
  assign bus.mem_re    = (c_gnt & ~bus.c_we) | (v_gnt & ~bus.v_we);
  assign bus.mem_we    = (c_gnt & bus.c_we) | (v_gnt & bus.v_we);
  assign bus.mem_addr  = c_gnt ? bus.c_addr : v_gnt ? bus.v_addr : '0;
  assign bus.mem_wdata = c_gnt ? bus.c_wdata : v_gnt ? bus.v_wdata : '0;
  assign bus.c_rvalid  = rd_owner[0];
  assign bus.v_rvalid  = rd_owner[1];
  assign bus.c_rdata   = rd_owner[0] ? bus.mem_rdata : c_rdata_q;
  assign bus.v_rdata   = rd_owner[1] ? bus.mem_rdata : v_rdata_q;
  // Arbitration FSM, round-robin history, burst length and pending read owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= 8'd0;
      rd_owner  <= 2'b00;
    end else begin
      rd_owner <= {v_gnt & ~bus.v_we, c_gnt & ~bus.c_we};
      if (state == IDLE) begin
        if (c_gnt | v_gnt) rr_last <= v_gnt;
        if (v_gnt & bus.v_lock & ~(bus.c_req & (MAX <= 8'd1))) begin
          state     <= BURST;
          burst_cnt <= 8'd1;
        end
      end else if (leave_burst) begin
        state     <= IDLE;
        rr_last   <= 1'b1;
        burst_cnt <= 8'd0;
      end else if (v_gnt) begin
        burst_cnt <= cnt_nxt;
      end
    end
  end
  // Hold the last returned read word per port between read returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rdata_q <= '0;
      v_rdata_q <= '0;
    end else begin
      if (rd_owner[0]) c_rdata_q <= bus.mem_rdata;
      if (rd_owner[1]) v_rdata_q <= bus.mem_rdata;
    end
  end
`ifdef CPU_MEM_ARB_PERF_EN
  // Saturating per-port count of cycles spent requesting without a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_wait_cnt <= 16'd0;
      v_wait_cnt <= 16'd0;
    end else if (perf_clr) begin
      c_wait_cnt <= 16'd0;
      v_wait_cnt <= 16'd0;
    end else begin
      if (bus.c_req & ~c_gnt & (c_wait_cnt != 16'hFFFF)) c_wait_cnt <= c_wait_cnt + 16'd1;
      if (bus.v_req & ~v_gnt & (v_wait_cnt != 16'hFFFF)) v_wait_cnt <= v_wait_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed self-checking bench for cpu_mem_arbiter with a write-first synchronous memory model
module tb_cpu_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] mem [256];
  logic [15:0] mrd;
`ifdef CPU_MEM_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [15:0] c_wait_cnt;
  logic [15:0] v_wait_cnt;
`endif
  cpu_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bif ();
  cpu_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
`ifdef CPU_MEM_ARB_PERF_EN
    ,
    .perf_clr(perf_clr),
    .c_wait_cnt(c_wait_cnt),
    .v_wait_cnt(v_wait_cnt)
`endif
  );
  always #5 clk = ~clk;
  // memory model: reset preloads A5xx pattern, 1-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'hA500 | 16'(k);
      mrd <= 16'h0;
    end else begin
      if (bif.mem_we) mem[bif.mem_addr[7:0]] <= bif.mem_wdata;
      if (bif.mem_re) mrd <= mem[bif.mem_addr[7:0]];
    end
  end
  assign bif.mem_rdata = mrd;
  task automatic idle_inputs;
    bif.c_req = 0; bif.c_we = 0; bif.c_addr = 16'h0; bif.c_wdata = 16'h0;
    bif.v_req = 0; bif.v_lock = 0; bif.v_we = 0; bif.v_addr = 16'h0; bif.v_wdata = 16'h0;
  endtask
  task automatic do_reset;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic test_reset;
    do_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({bif.c_gnt, bif.v_gnt, bif.c_rvalid, bif.v_rvalid, bif.mem_re, bif.mem_we} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000", {bif.c_gnt, bif.v_gnt, bif.c_rvalid, bif.v_rvalid, bif.mem_re, bif.mem_we});
    end
    n_cmp++;
    if ({bif.c_rdata, bif.v_rdata} !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 0", {bif.c_rdata, bif.v_rdata});
    end
    n_cmp++;
    if ({bif.mem_addr, bif.mem_wdata} !== 32'h0) begin
      n_err++; $display("FAIL reset_mem_bus: got %h want 0", {bif.mem_addr, bif.mem_wdata});
    end
  endtask
  task automatic test_cpu_rw;
    do_reset();
    bif.c_req = 1; bif.c_we = 1; bif.c_addr = 16'h0010; bif.c_wdata = 16'h1234;
    #1;
    n_cmp++;
    if ({bif.c_gnt, bif.v_gnt, bif.mem_we, bif.mem_re, bif.mem_addr, bif.mem_wdata} !== {4'b1010, 16'h0010, 16'h1234}) begin
      n_err++; $display("FAIL cpu_write: got %h want %h", {bif.c_gnt, bif.v_gnt, bif.mem_we, bif.mem_re, bif.mem_addr, bif.mem_wdata}, {4'b1010, 16'h0010, 16'h1234});
    end
    @(posedge clk); #1;
    bif.c_we = 0;
    #1;
    n_cmp++;
    if ({bif.c_rvalid, bif.c_gnt, bif.mem_re, bif.mem_we, bif.mem_addr} !== {4'b0110, 16'h0010}) begin
      n_err++; $display("FAIL cpu_read_grant: got %h want %h", {bif.c_rvalid, bif.c_gnt, bif.mem_re, bif.mem_we, bif.mem_addr}, {4'b0110, 16'h0010});
    end
    @(posedge clk); #1;
    bif.c_req = 0;
    #1;
    n_cmp++;
    if ({bif.c_rvalid, bif.mem_re, bif.c_rdata} !== {2'b10, 16'h1234}) begin
      n_err++; $display("FAIL cpu_read_data: got %h want %h", {bif.c_rvalid, bif.mem_re, bif.c_rdata}, {2'b10, 16'h1234});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bif.c_rvalid, bif.c_rdata} !== {1'b0, 16'h1234}) begin
      n_err++; $display("FAIL cpu_rdata_hold: got %h want %h", {bif.c_rvalid, bif.c_rdata}, {1'b0, 16'h1234});
    end
  endtask
  task automatic test_round_robin;
    logic ec;
    do_reset();
    bif.c_req = 1; bif.c_addr = 16'h0020; bif.v_req = 1; bif.v_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      ec = (i % 2 == 0);
      #1;
      n_cmp++;
      if ({bif.c_gnt, bif.v_gnt} !== {ec, !ec}) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {bif.c_gnt, bif.v_gnt}, {ec, !ec});
      end
      if (i > 0) begin
        n_cmp++;
        if ({bif.c_rvalid, bif.v_rvalid, (ec ? bif.v_rdata : bif.c_rdata)} !== {!ec, ec, (ec ? 16'hA530 : 16'hA520)}) begin
          n_err++; $display("FAIL rr_return[%0d]: got %h want %h", i, {bif.c_rvalid, bif.v_rvalid, (ec ? bif.v_rdata : bif.c_rdata)}, {!ec, ec, (ec ? 16'hA530 : 16'hA520)});
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask
  task automatic test_burst_max;
    logic ec;
    do_reset();
    bif.v_req = 1; bif.v_lock = 1; bif.v_addr = 16'h0030; bif.c_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) bif.c_req = 1;
      ec = (i == 8);
      #1;
      n_cmp++;
      if ({bif.c_gnt, bif.v_gnt} !== {ec, !ec}) begin
        n_err++; $display("FAIL burst_max[%0d]: got %b want %b", i, {bif.c_gnt, bif.v_gnt}, {ec, !ec});
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask
  task automatic test_burst_sat;
    int g;
    do_reset();
    g = 0;
    bif.v_req = 1; bif.v_lock = 1; bif.v_addr = 16'h0031;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bif.v_gnt === 1'b1 && bif.c_gnt === 1'b0) g++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (g !== 10) begin
      n_err++; $display("FAIL burst_sat_grants: got %0d want 10", g);
    end
    bif.v_req = 0; bif.c_req = 1;
    #1;
    n_cmp++;
    if ({bif.c_gnt, bif.v_gnt} !== 2'b00) begin
      n_err++; $display("FAIL burst_blocks_c: got %b want 00", {bif.c_gnt, bif.v_gnt});
    end
    @(posedge clk); #2;
    n_cmp++;
    if ({bif.c_gnt, bif.v_gnt} !== 2'b10) begin
      n_err++; $display("FAIL burst_exit_c: got %b want 10", {bif.c_gnt, bif.v_gnt});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask
  task automatic test_burst_lock_drop;
    do_reset();
    bif.v_req = 1; bif.v_lock = 1; bif.v_addr = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bif.v_lock = 0;
      #1;
      n_cmp++;
      if ({bif.c_gnt, bif.v_gnt, bif.mem_addr} !== {2'b01, 16'h0030}) begin
        n_err++; $display("FAIL lock_drop[%0d]: got %h want %h", i, {bif.c_gnt, bif.v_gnt, bif.mem_addr}, {2'b01, 16'h0030});
      end
      @(posedge clk); #1;
    end
    bif.v_req = 0; bif.c_req = 1; bif.c_addr = 16'h0021;
    #1;
    n_cmp++;
    if ({bif.c_gnt, bif.v_gnt, bif.v_rvalid, bif.v_rdata} !== {3'b101, 16'hA530}) begin
      n_err++; $display("FAIL lock_drop_c: got %h want %h", {bif.c_gnt, bif.v_gnt, bif.v_rvalid, bif.v_rdata}, {3'b101, 16'hA530});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask
  task automatic test_reset_mid_burst;
    do_reset();
    bif.v_req = 1; bif.v_lock = 1; bif.v_addr = 16'h0030;
    #1;
    n_cmp++;
    if (bif.v_gnt !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_setup: got %b want 1", bif.v_gnt);
    end
    @(posedge clk); #3;
    rst = 1;
    #1;
    n_cmp++;
    if ({bif.v_rvalid, bif.v_rdata} !== 17'h0) begin
      n_err++; $display("FAIL mid_rst_async: got %h want 0", {bif.v_rvalid, bif.v_rdata});
    end
    @(posedge clk); #1;
    rst = 0;
    bif.c_req = 1; bif.v_lock = 0;
    #1;
    n_cmp++;
    if ({bif.v_rvalid, bif.c_gnt, bif.v_gnt} !== 3'b010) begin
      n_err++; $display("FAIL mid_rst_after: got %b want 010", {bif.v_rvalid, bif.c_gnt, bif.v_gnt});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_cpu_rw();
    test_round_robin();
    test_burst_max();
    test_burst_sat();
    test_burst_lock_drop();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the single data/write port of cpu_memory between two requesters: the CPU load/store stage (port C) and the VPU/DMA loader (port V).
- The instruction read port is not touched by this block.
- Arbitration is round-robin, with an optional locked burst mode for V.
- Read data is returned on a registered valid strobe, aligned to the memory's 1-cycle synchronous read.

Parameters:
ADDR_W, 16, address width of both requesters and the memory port
DATA_W, 16, data width
MAX_BURST, 8, maximum consecutive locked grants to V before a forced release (1..255)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous reset, active-high
c_req  in  1  CPU access request, held until granted
c_we  in  1  CPU write (1) / read (0)
c_addr  in  ADDR_W  CPU address
c_wdata  in  DATA_W  CPU write data
c_gnt  out  1  CPU granted this cycle (combinational)
c_rvalid  out  1  CPU read data valid
c_rdata  out  DATA_W  CPU read data
v_req  in  1  VPU request
v_lock  in  1  VPU requests to keep ownership after this grant
v_we  in  1  VPU write/read
v_addr  in  ADDR_W  VPU address
v_wdata  in  DATA_W  VPU write data
v_gnt  out  1  VPU granted this cycle
v_rvalid  out  1  VPU read data valid
v_rdata  out  DATA_W  VPU read data
mem_re  out  1  memory data-port read enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory data address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re

Behaviour:
- State: FSM {IDLE, BURST}, rr_last (last winner, 0=C 1=V), burst_cnt[7:0], rd_owner (2-bit one-hot, registered).
- Reset values:
  - State IDLE, rr_last=1 (C wins the first tie), burst_cnt=0, rd_owner=0.
  - All gnt and rvalid outputs are 0; rdata outputs are 0.
- Grant in IDLE:
  - Only one requester active: it wins.
  - Both active: the one not equal to rr_last wins.
  - Winner's gnt=1 in the same cycle; rr_last updates on the clock edge.
- Memory drive:
  - mem_* are muxed from the winner combinationally: mem_re = gnt & ~we, mem_we = gnt & we.
  - No grant: mem_re = mem_we = 0; mem_addr and mem_wdata hold 0.
- Read return:
  - rd_owner registers {v_gnt & ~v_we, c_gnt & ~c_we}.
  - Next cycle, the matching rvalid=1 and its rdata = mem_rdata; the other port's rdata holds its last value.
- Writes produce no rvalid. Write-then-read to the same address on consecutive cycles returns the new data (the memory is write-first).
- IDLE->BURST: on a V grant with v_lock=1; burst_cnt=1.
- In BURST:
  - V has exclusive priority; C is not granted even if requesting.
  - Each V grant increments burst_cnt.
- BURST->IDLE, any of:
  - v_lock=0 at a V grant (that grant is the last of the burst);
  - v_req=0 for a cycle;
  - burst_cnt reaches MAX_BURST and c_req=1 (forced release).
  - On leaving BURST, rr_last=1, so a waiting C wins the next cycle.
- burst_cnt == MAX_BURST with c_req=0: the burst continues and burst_cnt saturates.
- Reset asserted mid-burst or mid-read: immediate return to reset values; a pending rvalid is dropped.
- No request is ever granted while its req=0. Grants never overlap: c_gnt & v_gnt == 0 always.
- Maximum C wait is MAX_BURST+1 cycles.

Optional Feature:
- Macro: CPU_MEM_ARB_PERF_EN.
- When defined, the block adds outputs c_wait_cnt[15:0] and v_wait_cnt[15:0].
  - Each increments every cycle its req=1 and gnt=0, and saturates at 16'hFFFF.
  - A synchronous clear input perf_clr zeroes both counters; both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle -> all gnt, rvalid, mem_re and mem_we are 0; rdata outputs are 0.
- C alone writes 0x1234 to addr 0x0010, then reads it -> c_gnt on each cycle; c_rvalid one cycle after the read grant with c_rdata=0x1234.
- c_req and v_req held high together, no lock, 6 cycles -> grants alternate C,V,C,V,C,V; never both high.
- V locked burst of 12 reads with c_req=1 throughout, MAX_BURST=8 -> 8 V grants, then c_gnt; then V resumes.
- V locked burst of 3 with v_lock dropping on the 3rd grant, c_req=0 -> state returns to IDLE; a subsequent C request is granted the same cycle.
- rst pulsed 1 cycle during a V burst with a read outstanding -> v_rvalid stays 0; the next grant follows reset tie-break (C first).
